fir_mac_sequencer: RTL and testbench

//  Time-multiplexed controller for a single-MAC FIR engine. Accepts one sample per

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_sat_shift.sv | 21 ++
 rtl/fir_mac_sequencer.sv | 102 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed single-MAC FIR engine.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Accumulator width that cannot overflow over a full MAC pass.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned taps);
    return 2 * width + $clog2(taps);
  endfunction

  // Clip a wide signed value into the signed range of a width-bit result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Scales the accumulator back to sample format: floor shift by FRAC, then saturate.
module fir_sat_shift #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = WIDTH - 1,
  parameter int unsigned ACC_W = 34
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] y_c
);
  import fir_pkg::*;

  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      clipped;

  always_comb begin
    shifted = acc >>> FRAC;
    clipped = saturate(64'(shifted), WIDTH);
    y_c     = WIDTH'(clipped);
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Single-MAC FIR controller: accept one sample, run NUM_TAPS MAC cycles, hold the
// saturated result until downstream takes it.
module fir_mac_sequencer import fir_pkg::*; #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned FRAC     = WIDTH - 1,
  parameter int unsigned ACC_W    = acc_w(WIDTH, NUM_TAPS),
  // One spare address bit so out-of-range tap indices reach the bank and get rejected.
  localparam int unsigned ADDR_W  = $clog2(NUM_TAPS) + 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  Xn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  Yn,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [WIDTH-1:0]  coef_wdata,
  output logic                     coef_err,
  output logic                     busy
);

  localparam int unsigned TAP_W  = $clog2(NUM_TAPS);
  localparam int unsigned PROD_W = 2 * WIDTH;

  state_t                  state;
  logic signed [WIDTH-1:0] x_dly [NUM_TAPS];
  logic signed [WIDTH-1:0] coef  [NUM_TAPS];
  logic signed [ACC_W-1:0] acc;
  logic [TAP_W-1:0]        tap;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_next_c;
  logic signed [WIDTH-1:0]  y_sat_c;
  logic                     coef_ok_c;

  assign prod_c     = PROD_W'(x_dly[tap]) * PROD_W'(coef[tap]);
  assign acc_next_c = acc + ACC_W'(prod_c);
  assign coef_ok_c  = coef_we && (state != S_MAC) && (coef_addr < ADDR_W'(NUM_TAPS));
  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  fir_sat_shift #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_sat (
    .acc (acc_next_c),
    .y_c (y_sat_c)
  );

  // Sequencer, delay line and coefficient bank.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_IDLE;
      acc       <= '0;
      tap       <= '0;
      Yn        <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        x_dly[k] <= '0;
        coef[k]  <= '0;
      end
    end else begin
      coef_err <= coef_we && !coef_ok_c;
      if (coef_ok_c) coef[coef_addr[TAP_W-1:0]] <= coef_wdata;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_dly[0] <= Xn;
            for (int unsigned k = 1; k < NUM_TAPS; k++) x_dly[k] <= x_dly[k-1];
            acc   <= '0;
            tap   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next_c;
          tap <= tap + TAP_W'(1);
          if (tap == TAP_W'(NUM_TAPS - 1)) begin
            Yn        <= y_sat_c;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a convolution-level reference model.
module tb_fir_mac_sequencer;

  localparam int unsigned NT = 4;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [15:0] Xn = '0;
  logic [15:0] coef_wdata = '0;
  logic [2:0]  coef_addr = '0;
  logic        in_ready, out_valid, coef_err, busy;
  logic [15:0] Yn;

  int n_cmp = 0;
  int n_err = 0;

  int mx [NT];
  int mc [NT];

  fir_mac_sequencer dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Xn         (Xn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Yn         (Yn),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int k = 0; k < NT; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
  endfunction

  function automatic void m_push(input logic [15:0] v);
    for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = $signed(v);
  endfunction

  function automatic void m_coef(input int a, input logic [15:0] d);
    mc[a] = $signed(d);
  endfunction

  // y = clamp(floor(sum(x[k]*c[k]) / 2^15))
  function automatic logic [15:0] m_out();
    longint s;
    s = 0;
    for (int k = 0; k < NT; k++) s += longint'(mx[k]) * longint'(mc[k]);
    s = s >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d, output logic err);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
    err = coef_err;
  endtask

  // Push one sample through with out_ready=1; returns result, latency and whether it came.
  task automatic run_sample(input logic [15:0] x, output logic [15:0] y,
                            output int lat, output bit seen);
    @(negedge clk);
    in_valid = 1'b1; Xn = x;
    @(negedge clk);
    in_valid = 1'b0;
    m_push(x);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (out_valid) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    y = Yn;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #2 arst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
    arst = 1'b0;
    m_clear();
    @(negedge clk);
    n_cmp++; if (Yn !== 16'h0) begin n_err++; $display("FAIL reset_yn: got %h want 0000", Yn); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL reset_coef_err: got %b want 0", coef_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic load_impulse_coefs(input string tag);
    logic [15:0] cv [NT];
    logic        err;
    cv[0] = 16'h4000; cv[1] = 16'h2000; cv[2] = 16'h1000; cv[3] = 16'h0800;
    for (int k = 0; k < NT; k++) begin
      write_coef(3'(k), cv[k], err);
      m_coef(k, cv[k]);
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL %s_coef_wr%0d: coef_err got %b want 0", tag, k, err); end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] xs [NT];
    logic [15:0] y, e;
    int lat; bit seen;
    load_impulse_coefs("impulse");
    xs[0] = 16'h7FFF; xs[1] = 16'h0; xs[2] = 16'h0; xs[3] = 16'h0;
    for (int i = 0; i < NT; i++) begin
      run_sample(xs[i], y, lat, seen);
      e = m_out();
      n_cmp++; if (!seen || lat != NT) begin n_err++; $display("FAIL impulse_latency%0d: got %0d (seen %b) want %0d", i, lat, seen, NT); end
      n_cmp++; if (y !== e) begin n_err++; $display("FAIL impulse_y%0d: got %h want %h", i, y, e); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] y, e, xv;
    logic        err;
    int lat; bit seen;
    for (int k = 0; k < NT; k++) begin write_coef(3'(k), 16'h7FFF, err); m_coef(k, 16'h7FFF); end
    for (int i = 0; i < 4 * NT; i++) begin
      xv = (i / NT == 1) ? 16'h7FFF : (i / NT == 3) ? 16'h8000 : 16'h0000;
      run_sample(xv, y, lat, seen);
      e = m_out();
      n_cmp++; if (!seen || y !== e) begin n_err++; $display("FAIL sat_y%0d: got %h (seen %b) want %h", i, y, seen, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] xa, xb, y0, e, cw;
    int lat;
    xa = 16'($urandom); xb = 16'($urandom); cw = 16'($urandom);
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; Xn = xa;
    @(negedge clk); Xn = xb;
    m_push(xa); e = m_out();
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (!out_valid || lat != NT) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, NT); end
    y0 = Yn;
    n_cmp++; if (y0 !== e) begin n_err++; $display("FAIL bp_y: got %h want %h", y0, e); end
    coef_we = 1'b1; coef_addr = 3'd1; coef_wdata = cw;
    @(negedge clk); coef_we = 1'b0; m_coef(1, cw);
    n_cmp++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL bp_out_coef_wr: coef_err got %b want 0", coef_err); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (Yn !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d: Yn %h ov %b ir %b busy %b want %h 1 0 1", i, Yn, out_valid, in_ready, busy, y0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: ov %b ir %b want 0 1", out_valid, in_ready); end
    @(negedge clk); in_valid = 1'b0;
    m_push(xb); e = m_out();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_next_accept: busy got %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (!out_valid || lat != NT || Yn !== e) begin n_err++; $display("FAIL bp_next_y: got %h lat %0d want %h lat %0d", Yn, lat, e, NT); end
    @(negedge clk);
  endtask

  task automatic test_coef_err();
    logic [15:0] xa, y, e;
    logic        err;
    int lat; bit seen;
    write_coef(3'd0, 16'h4000, err); m_coef(0, 16'h4000);
    xa = 16'($urandom);
    @(negedge clk); in_valid = 1'b1; Xn = xa;
    @(negedge clk); in_valid = 1'b0; m_push(xa);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h7FFF;
    @(negedge clk); coef_we = 1'b0;
    n_cmp++; if (coef_err !== 1'b1) begin n_err++; $display("FAIL cerr_mac_pulse: got %b want 1", coef_err); end
    @(negedge clk);
    n_cmp++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL cerr_mac_pulse_end: got %b want 0", coef_err); end
    lat = 2;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    e = m_out();
    n_cmp++; if (!out_valid || lat != NT || Yn !== e) begin n_err++; $display("FAIL cerr_mac_y: got %h lat %0d want %h lat %0d", Yn, lat, e, NT); end
    @(negedge clk);
    run_sample(16'h7FFF, y, lat, seen); e = m_out();
    n_cmp++; if (!seen || y !== e) begin n_err++; $display("FAIL cerr_old_c0: got %h want %h", y, e); end
    write_coef(3'd4, 16'h1234, err);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL cerr_addr4_pulse: got %b want 1", err); end
    run_sample(16'($urandom), y, lat, seen); e = m_out();
    n_cmp++; if (!seen || y !== e) begin n_err++; $display("FAIL cerr_addr4_bank: got %h want %h", y, e); end
  endtask

  task automatic test_same_edge();
    logic [15:0] xa, d, e;
    int lat;
    xa = 16'($urandom); d = 16'($urandom);
    @(negedge clk);
    in_valid = 1'b1; Xn = xa;
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = d;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    m_coef(0, d); m_push(xa); e = m_out();
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (!out_valid || Yn !== e) begin n_err++; $display("FAIL same_edge_y: got %h want %h", Yn, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] y, e;
    bit ov_seen;
    int lat; bit seen;
    @(negedge clk); in_valid = 1'b1; Xn = 16'h7FFF;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk); arst = 1'b0;
    m_clear();
    ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) ov_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (ov_seen !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_output: ov_seen %b busy %b want 0 0", ov_seen, busy); end
    load_impulse_coefs("rstmid");
    run_sample(16'h7FFF, y, lat, seen); e = m_out();
    n_cmp++; if (!seen || y !== e) begin n_err++; $display("FAIL rstmid_impulse: got %h want %h", y, e); end
  endtask

  task automatic test_random();
    logic [15:0] y, e, xv, d;
    logic [2:0]  a;
    logic        err;
    int lat; bit seen;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 3'($urandom_range(0, 4)); d = 16'($urandom);
        write_coef(a, d, err);
        if (a < 3'(NT)) m_coef(int'(a), d);
        n_cmp++; if (err !== (a >= 3'(NT))) begin n_err++; $display("FAIL rand_coef_err%0d: got %b addr %0d", i, err, a); end
      end
      case ($urandom_range(0, 3))
        0: xv = 16'h7FFF;
        1: xv = 16'h8000;
        default: xv = 16'($urandom);
      endcase
      run_sample(xv, y, lat, seen);
      e = m_out();
      n_cmp++; if (!seen || lat != NT || y !== e) begin n_err++; $display("FAIL rand_y%0d: got %h lat %0d want %h lat %0d", i, y, lat, e, NT); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_coef_err();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
